// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment
// patterns, special decode codes and the scan-decoder state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h03;
  localparam logic [6:0] SEG_7     = 7'h58;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK   = 4'hE;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    HELD
  } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the segment encoder: 7-bit active-low pattern
// (g..a, dp excluded) back to a BCD code, blank code or invalid code.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Display-bus monitor: debounces each multiplexed anode dwell, decodes the
// segment pattern per digit position and pulses frame_valid per full refresh.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic                    anode_err
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] COMMIT_AT = CW'(SETTLE_CYCLES - 2);

  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic [CW-1:0]         cnt;
  scan_state_t           state, state_next;
  logic                  match, all_high, commit, single;
  logic [3:0]            code;
  logic                  invalid;

  seg_pattern_decode u_decode (
    .pattern (seg_q[6:0]),
    .code    (code),
    .invalid (invalid)
  );

  assign match     = (seg_in == seg_q) && (an_in == an_q);
  assign all_high  = &an_in;
  assign single    = $onehot(~an_q);
  assign seen_next = seen | ~an_q;

  // Commit fires on the edge that brings the SETTLE_CYCLES-th identical sample.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    if (all_high) begin
      state_next = IDLE;
    end else if (!match) begin
      state_next = SETTLING;
    end else begin
      case (state)
        SETTLING: begin
          if (cnt >= COMMIT_AT) begin
            state_next = HELD;
            commit     = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= 8'hFF;
      an_q  <= '1;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      seg_q <= seg_in;
      an_q  <= an_in;
      state <= state_next;
      if (!match) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_out  <= '1;
      dp_out      <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (commit && single) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!an_q[i]) begin
            digits_out[4*i +: 4] <= code;
            dp_out[i]            <= ~seg_q[7];
          end
        end
        if (&seen_next) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

  // A new error event takes priority over a same-cycle clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      if (commit && single && invalid) begin
        pattern_err <= 1'b1;
      end else if (clear_err) begin
        pattern_err <= 1'b0;
      end
      if (commit && !single) begin
        anode_err <= 1'b1;
      end else if (clear_err) begin
        anode_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scan, latency, glitch, blank/invalid,
// multi-anode and asynchronous reset cases against hand-computed values.
module tb_seg_scan_decoder;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    seg_in = 8'hFF;
  logic [ND-1:0] an_in = '1;
  logic          clear_err = 1'b0;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] dp_out;
  logic          frame_valid;
  logic          pattern_err;
  logic          anode_err;

  int errors = 0;
  int checks = 0;
  int frame_count = 0;
  int frame_base;

  seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .clear_err   (clear_err),
    .digits_out  (digits_out),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) frame_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] seg, input logic [ND-1:0] an, input int cycles);
    seg_in = seg;
    an_in  = an;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [7:0] scan_a [ND];
    logic [7:0] scan_b [ND];
    scan_a = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h83};
    scan_b = '{8'h98, 8'h80, 8'hD8, 8'h83, 8'h92, 8'hC0};

    repeat (3) @(negedge clk);
    checkOutput("reset_digits", 32'(digits_out), 32'hFFFFFF);
    checkOutput("reset_dp", 32'(dp_out), 32'h0);
    checkOutput("reset_frame", 32'(frame_valid), 32'h0);
    checkOutput("reset_perr", 32'(pattern_err), 32'h0);
    checkOutput("reset_aerr", 32'(anode_err), 32'h0);
    reset = 1'b1;
    applyStimulus(8'hFF, '1, 2);

    // Short glitch on position 0 must not commit
    applyStimulus(8'h99, 6'b111110, 3);
    applyStimulus(8'hFF, '1, 3);
    checkOutput("glitch_digits", 32'(digits_out), 32'hFFFFFF);

    frame_base = frame_count;
    for (int i = 0; i < ND; i++) begin
      applyStimulus(scan_a[i], ~(6'b1 << i), 8);
      if (i == ND - 2) checkOutput("scan_no_early_frame", 32'(frame_count - frame_base), 32'd0);
    end
    applyStimulus(8'hFF, '1, 2);
    checkOutput("scan_digits", 32'(digits_out), 32'h654321);
    checkOutput("scan_frames", 32'(frame_count - frame_base), 32'd1);
    checkOutput("scan_dp", 32'(dp_out), 32'h0);
    checkOutput("scan_perr", 32'(pattern_err), 32'h0);
    checkOutput("scan_aerr", 32'(anode_err), 32'h0);

    // Digit 8 with dp lit on position 2, commit on the 4th sampling edge
    applyStimulus(8'h00, 6'b111011, 3);
    checkOutput("lat_before", 32'(digits_out), 32'h654321);
    applyStimulus(8'h00, 6'b111011, 1);
    checkOutput("lat_digits", 32'(digits_out), 32'h654821);
    checkOutput("lat_dp", 32'(dp_out), 32'b000100);
    applyStimulus(8'hFF, '1, 2);

    applyStimulus(8'hFF, 6'b111101, 6);
    checkOutput("blank_digits", 32'(digits_out), 32'h6548E1);
    checkOutput("blank_perr", 32'(pattern_err), 32'h0);
    applyStimulus(8'hAA, 6'b111101, 6);
    checkOutput("inval_digits", 32'(digits_out), 32'h6548F1);
    checkOutput("inval_perr", 32'(pattern_err), 32'h1);
    seg_in = 8'hFF;
    an_in = '1;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("clear_perr", 32'(pattern_err), 32'h0);
    applyStimulus(8'hFF, '1, 1);

    // Two anodes low; clear_err lands on the commit edge and must lose
    applyStimulus(8'hC0, 6'b111100, 3);
    clear_err = 1'b1;
    applyStimulus(8'hC0, 6'b111100, 1);
    clear_err = 1'b0;
    checkOutput("anode_err_wins", 32'(anode_err), 32'h1);
    applyStimulus(8'hC0, 6'b111100, 2);
    checkOutput("anode_digits", 32'(digits_out), 32'h6548F1);
    checkOutput("anode_dp", 32'(dp_out), 32'b000100);
    applyStimulus(8'hFF, '1, 2);

    applyStimulus(8'hB0, 6'b110111, 2);
    #2 reset = 1'b0;
    #1;
    checkOutput("areset_digits", 32'(digits_out), 32'hFFFFFF);
    checkOutput("areset_dp", 32'(dp_out), 32'h0);
    checkOutput("areset_frame", 32'(frame_valid), 32'h0);
    checkOutput("areset_perr", 32'(pattern_err), 32'h0);
    checkOutput("areset_aerr", 32'(anode_err), 32'h0);
    @(negedge clk);
    applyStimulus(8'hFF, '1, 1);
    reset = 1'b1;
    applyStimulus(8'hFF, '1, 1);

    frame_base = frame_count;
    for (int i = 0; i < ND; i++) begin
      applyStimulus(scan_b[i], ~(6'b1 << i), 8);
    end
    applyStimulus(8'hFF, '1, 2);
    checkOutput("rescan_digits", 32'(digits_out), 32'h056789);
    checkOutput("rescan_frames", 32'(frame_count - frame_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
